l1_vlsu_miss_handler: RTL and testbench

- Collects per-lane cache misses from one vector load/store (VLSU) access in the L1 data cache.
- Removes duplicate 64-byte lines and issues one refill per unique line, in order.
- Raises ready_for_replay_o once all refills complete, so the VLSU can replay the access.
- Sits between the L1 lookup pipeline and the refill/miss path.

---
 rtl/l1_vlsu_miss_handler_if.sv | 36 +++
 rtl/l1_vlsu_miss_handler.sv | 159 +++++++++++++++
 tb/tb_l1_vlsu_miss_handler.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/l1_vlsu_miss_handler_if.sv
// +----------------------------------------------------------------------------+
// | l1_vlsu_miss_handler_if                                                    |
// | Lookup-side and refill-side signals of the VLSU miss handler.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface l1_vlsu_miss_handler_if #(
  parameter int NUM_LANES  = 8,
  parameter int MAX_MISSES = 8
);
  localparam int CNT_W = $clog2(MAX_MISSES + 1);

  logic                      vlsu_req_i;
  logic [NUM_LANES-1:0]      lane_miss_i;
  logic [NUM_LANES*64-1:0]   lane_addr_i;
  logic                      any_miss_i;
  logic                      refill_req_o;
  logic [63:0]               refill_addr_o;
  logic                      refill_done_i;
  logic                      busy_o;
  logic                      ready_for_replay_o;
  logic [CNT_W-1:0]          miss_count_o;

  modport slave (
    input  vlsu_req_i, lane_miss_i, lane_addr_i, any_miss_i, refill_done_i,
    output refill_req_o, refill_addr_o, busy_o, ready_for_replay_o, miss_count_o
  );

  modport master (
    output vlsu_req_i, lane_miss_i, lane_addr_i, any_miss_i, refill_done_i,
    input  refill_req_o, refill_addr_o, busy_o, ready_for_replay_o, miss_count_o
  );
endinterface

`default_nettype wire

// File: rtl/l1_vlsu_miss_handler.sv
// +----------------------------------------------------------------------------+
// | l1_vlsu_miss_handler                                                       |
// | Dedups per-lane line misses of one VLSU access and issues refills in       |
// | first-seen order. Optional macro VLSU_MISS_STATS_EN adds stat counters.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module l1_vlsu_miss_handler #(
  parameter int NUM_LANES  = 8,
  parameter int TAG_W      = 53,
  parameter int INDEX_W    = 5,
  parameter int MAX_MISSES = 8
) (
  input wire                     clk_i,
  input wire                     rst_i,
  l1_vlsu_miss_handler_if.slave  bus
`ifdef VLSU_MISS_STATS_EN
  ,
  output logic [31:0]            stat_refills_o,
  output logic [31:0]            stat_dedup_o
`endif
);

  localparam int LINE_W = TAG_W + INDEX_W;
  localparam int LIDX_W = $clog2(NUM_LANES + 1);
  localparam int LSEL_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CNT_W  = $clog2(MAX_MISSES + 1);
  localparam int TIDX_W = (MAX_MISSES > 1) ? $clog2(MAX_MISSES) : 1;
  localparam logic [LIDX_W-1:0] C_LANES = LIDX_W'(NUM_LANES);
  localparam logic [CNT_W-1:0]  C_MAX   = CNT_W'(MAX_MISSES);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    COLLECT     = 3'd1,
    REFILL_REQ  = 3'd2,
    REFILL_WAIT = 3'd3,
    REPLAY      = 3'd4
  } state_t;

  state_t                r_state, w_state_next;
  logic [LIDX_W-1:0]     r_lane_idx;
  logic [NUM_LANES-1:0]  r_lane_miss;
  logic [LINE_W-1:0]     r_lane_line [NUM_LANES];
  logic [LINE_W-1:0]     r_table [MAX_MISSES];
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      r_refill_idx, w_idx_next;
  logic                  r_refill_req, r_busy, r_ready;
  logic [63:0]           r_refill_addr;

  logic [LSEL_W-1:0]     w_lane_sel;
  logic [LINE_W-1:0]     w_cur_line;
  logic                  w_scan_valid, w_cur_miss, w_dup, w_append;
  logic [MAX_MISSES-1:0] w_hit;
  logic [NUM_LANES*6-1:0] w_unused_offset;

  assign w_lane_sel   = r_lane_idx[LSEL_W-1:0];
  assign w_cur_line   = r_lane_line[w_lane_sel];
  assign w_cur_miss   = r_lane_miss[w_lane_sel];
  assign w_scan_valid = (r_state == COLLECT) && (r_lane_idx != C_LANES);

  // Only valid entries count as hits, so lines appended earlier in this scan dedup later lanes.
  for (genvar j = 0; j < MAX_MISSES; j++) begin : g_match
    assign w_hit[j] = (CNT_W'(j) < r_count) && (r_table[j] == w_cur_line);
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_offs
    assign w_unused_offset[6*k +: 6] = bus.lane_addr_i[64*k +: 6];
  end

  assign w_dup    = |w_hit;
  assign w_append = w_scan_valid && w_cur_miss && !w_dup && (r_count != C_MAX);

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_refill_idx;
    case (r_state)
      IDLE:        if (bus.vlsu_req_i && bus.any_miss_i) w_state_next = COLLECT;
      COLLECT:     if (r_lane_idx == C_LANES)
                     w_state_next = (r_count != '0) ? REFILL_REQ : REPLAY;
      REFILL_REQ:  w_state_next = REFILL_WAIT;
      REFILL_WAIT: if (bus.refill_done_i) begin
                     w_idx_next   = r_refill_idx + CNT_W'(1);
                     w_state_next = (w_idx_next == r_count) ? REPLAY : REFILL_REQ;
                   end
      REPLAY:      if (!bus.vlsu_req_i) w_state_next = IDLE;
      default:     w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= IDLE;
      r_lane_idx    <= '0;
      r_lane_miss   <= '0;
      r_count       <= '0;
      r_refill_idx  <= '0;
      r_refill_req  <= 1'b0;
      r_busy        <= 1'b0;
      r_ready       <= 1'b0;
      r_refill_addr <= '0;
      for (int k = 0; k < NUM_LANES; k++) r_lane_line[k] <= '0;
      for (int j = 0; j < MAX_MISSES; j++) r_table[j] <= '0;
    end else begin
      r_state      <= w_state_next;
      r_refill_idx <= w_idx_next;
      r_busy       <= (w_state_next != IDLE);
      r_refill_req <= (w_state_next == REFILL_REQ);
      r_ready      <= (w_state_next == REPLAY);
      if (w_state_next == REFILL_REQ)
        r_refill_addr <= {r_table[w_idx_next[TIDX_W-1:0]], 6'b0};
      if (w_scan_valid)
        r_lane_idx <= r_lane_idx + LIDX_W'(1);
      if (w_append) begin
        r_table[r_count[TIDX_W-1:0]] <= w_cur_line;
        r_count                      <= r_count + CNT_W'(1);
      end
      if (r_state == IDLE && w_state_next == COLLECT) begin
        r_lane_idx   <= '0;
        r_lane_miss  <= bus.lane_miss_i;
        r_count      <= '0;
        r_refill_idx <= '0;
        for (int k = 0; k < NUM_LANES; k++) r_lane_line[k] <= bus.lane_addr_i[64*k+6 +: LINE_W];
        for (int j = 0; j < MAX_MISSES; j++) r_table[j] <= '0;
      end
    end
  end

  assign bus.refill_req_o       = r_refill_req;
  assign bus.refill_addr_o      = r_refill_addr;
  assign bus.busy_o             = r_busy;
  assign bus.ready_for_replay_o = r_ready;
  assign bus.miss_count_o       = r_count;

`ifdef VLSU_MISS_STATS_EN
  logic [31:0] r_stat_refills, r_stat_dedup;
  logic        w_dup_lane;

  assign w_dup_lane = w_scan_valid && w_cur_miss && w_dup;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stat_refills <= '0;
      r_stat_dedup   <= '0;
    end else begin
      if (w_state_next == REFILL_REQ && r_stat_refills != '1)
        r_stat_refills <= r_stat_refills + 32'd1;
      if (w_dup_lane && r_stat_dedup != '1)
        r_stat_dedup <= r_stat_dedup + 32'd1;
    end
  end

  assign stat_refills_o = r_stat_refills;
  assign stat_dedup_o   = r_stat_dedup;
`endif

endmodule

`default_nettype wire

// File: tb/tb_l1_vlsu_miss_handler.sv
// +----------------------------------------------------------------------------+
// | tb_l1_vlsu_miss_handler                                                    |
// | Scoreboard bench: expected refill lines queued at stimulus, popped on req. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_l1_vlsu_miss_handler;
  localparam int NL = 16;
  localparam int MM = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l1_vlsu_miss_handler_if #(.NUM_LANES(NL), .MAX_MISSES(MM)) bus ();

`ifdef VLSU_MISS_STATS_EN
  logic [31:0] stat_refills, stat_dedup;
`endif

  l1_vlsu_miss_handler #(.NUM_LANES(NL), .MAX_MISSES(MM)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
`ifdef VLSU_MISS_STATS_EN
    ,
    .stat_refills_o (stat_refills),
    .stat_dedup_o   (stat_dedup)
`endif
  );

  int          total = 0;
  int          bad = 0;
  logic [63:0] exp_q [$];
  bit          auto_ack = 1'b1;
  int          ack_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Refill monitor and responder: acks each request two cycles later.
  initial begin
    bus.refill_done_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.refill_done_i = 1'b0;
      if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0 && auto_ack) bus.refill_done_i = 1'b1;
      end
      if (bus.refill_req_o === 1'b1) begin
        chk("refill_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) chk("refill_addr", bus.refill_addr_o, exp_q.pop_front());
        ack_cnt = 2;
      end
    end
  end

  // Reference: unique lines in lane order, capped at table capacity.
  task automatic model(input logic [63:0] a [NL], input logic [NL-1:0] m, output int cnt);
    logic [63:0] seen [$];
    for (int k = 0; k < NL; k++) begin
      logic [63:0] ln;
      bit found;
      ln = a[k] & ~64'h3F;
      found = 1'b0;
      if (m[k]) begin
        foreach (seen[j]) if (seen[j] == ln) found = 1'b1;
        if (!found && seen.size() < MM) begin
          seen.push_back(ln);
          exp_q.push_back(ln);
        end
      end
    end
    cnt = seen.size();
  endtask

  task automatic run_access(input logic [63:0] a [NL], input logic [NL-1:0] m, input bit scramble);
    int cnt, cyc, first;
    model(a, m, cnt);
    @(negedge clk);
    bus.vlsu_req_i  = 1'b1;
    bus.lane_miss_i = m;
    bus.any_miss_i  = |m;
    for (int k = 0; k < NL; k++) bus.lane_addr_i[64*k +: 64] = a[k];
    cyc = 0;
    first = 0;
    while (!bus.ready_for_replay_o && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 2 && scramble) begin
        bus.lane_miss_i = ~bus.lane_miss_i;
        for (int k = 0; k < NL; k++) bus.lane_addr_i[64*k +: 64] = {$urandom, $urandom};
      end
      if (first == 0 && bus.refill_req_o) first = cyc;
    end
    chk("ready_for_replay", 64'(bus.ready_for_replay_o), 64'd1);
    if (cnt > 0) chk("first_req_latency", 64'(first), 64'(NL + 2));
    chk("refills_outstanding", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    @(negedge clk);
    bus.vlsu_req_i = 1'b0;
    @(posedge clk); #1;
    chk("busy_after_release", 64'(bus.busy_o), 64'd0);
    chk("ready_after_release", 64'(bus.ready_for_replay_o), 64'd0);
    chk("miss_count", 64'(bus.miss_count_o), 64'(cnt));
  endtask

  initial begin
    logic [63:0] a [NL];
    logic [NL-1:0] m;
    int cyc;

    rst = 1'b1;
    bus.vlsu_req_i  = 1'b0;
    bus.lane_miss_i = '0;
    bus.lane_addr_i = '0;
    bus.any_miss_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_refill_req", 64'(bus.refill_req_o), 64'd0);
    chk("rst_refill_addr", bus.refill_addr_o, 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_ready", 64'(bus.ready_for_replay_o), 64'd0);
    chk("rst_miss_count", 64'(bus.miss_count_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Request without any miss must not engage the handler.
    @(negedge clk);
    bus.vlsu_req_i  = 1'b1;
    bus.lane_miss_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("no_miss_busy", 64'(bus.busy_o), 64'd0);
    @(negedge clk);
    bus.vlsu_req_i = 1'b0;

    for (int k = 0; k < NL; k++) a[k] = 64'h0;
    a[0] = 64'h1000;
    run_access(a, NL'(1), 1'b0);

    a[0] = 64'h2000; a[1] = 64'h2008; a[2] = 64'h3000; a[3] = 64'h3018;
    a[4] = 64'h4000; a[5] = 64'h4020; a[6] = 64'h4030; a[7] = 64'h4038;
    run_access(a, NL'(16'h00FF), 1'b0);

    for (int k = 0; k < NL; k++) a[k] = 64'h5000 + 64'(8 * k);
    run_access(a, '1, 1'b0);

    a[3] = 64'h1234;
    run_access(a, NL'(16'h0008), 1'b0);

    for (int k = 0; k < NL; k++) a[k] = 64'h10000 + 64'(k) * 64'h40;
    run_access(a, NL'(16'h01FF), 1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NL; k++)
        a[k] = 64'h9000 + 64'($urandom_range(0, 11)) * 64'h40 + 64'($urandom_range(0, 63));
      m = NL'($urandom);
      if (m == '0) m = NL'(1);
      run_access(a, m, 1'b1);
    end

    // Reset while a refill is outstanding; a late ack must be ignored.
    auto_ack = 1'b0;
    for (int k = 0; k < NL; k++) a[k] = 64'h7000;
    exp_q.push_back(64'h7000);
    @(negedge clk);
    bus.vlsu_req_i  = 1'b1;
    bus.lane_miss_i = NL'(1);
    bus.any_miss_i  = 1'b1;
    for (int k = 0; k < NL; k++) bus.lane_addr_i[64*k +: 64] = a[k];
    cyc = 0;
    while (!bus.refill_req_o && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rstwait_req_seen", 64'(bus.refill_req_o), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_refill_req", 64'(bus.refill_req_o), 64'd0);
    chk("midrst_refill_addr", bus.refill_addr_o, 64'd0);
    chk("midrst_busy", 64'(bus.busy_o), 64'd0);
    chk("midrst_ready", 64'(bus.ready_for_replay_o), 64'd0);
    chk("midrst_miss_count", 64'(bus.miss_count_o), 64'd0);
    @(negedge clk);
    bus.vlsu_req_i = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    bus.refill_done_i = 1'b1;
    @(negedge clk);
    bus.refill_done_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("late_ack_busy", 64'(bus.busy_o), 64'd0);
    chk("late_ack_ready", 64'(bus.ready_for_replay_o), 64'd0);
    exp_q.delete();
    auto_ack = 1'b1;

    for (int k = 0; k < NL; k++) a[k] = 64'hA040 + 64'(k);
    run_access(a, NL'(16'h8001), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
